// File: rtl/spi_target_pkg.sv
// Shared SPI target definitions: mode encodings and idle fill.
// Imported by spi_target and spi_input_synchronizer.
package spi_target_pkg;

  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

  // Fill bit for the default idle word (all ones).
  localparam logic IDLE_FILL = 1'b1;

  function automatic logic mode_cpol(spi_mode_e m);
    return m[1];
  endfunction

  function automatic logic mode_cpha(spi_mode_e m);
    return m[0];
  endfunction

endpackage

// File: rtl/spi_input_synchronizer.sv
// 2-FF synchroniser with per-instance reset value.
// Ports: clock, reset_n, d (async pin), q (synced).
module spi_input_synchronizer
  import spi_target_pkg::*;
#(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spi_target.sv
// SPI target on the system clock: MSB-first word exchange, tx holding reg.
// Ports: clock/reset_n, sclk/mosi/cs/miso/miso_output_enable, tx_*/rx_*.
module spi_target
  import spi_target_pkg::*;
#(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0,
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD = {DATA_WIDTH{IDLE_FILL}}
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  cs,
  output logic                  miso,
  output logic                  miso_output_enable,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic sclk_sync, mosi_sync, cs_sync;

  spi_input_synchronizer #(.RESET_VALUE(CPOL)) u_sync_sclk (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (sclk),
    .q       (sclk_sync)
  );

  spi_input_synchronizer #(.RESET_VALUE(1'b0)) u_sync_mosi (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (mosi),
    .q       (mosi_sync)
  );

  spi_input_synchronizer #(.RESET_VALUE(1'b1)) u_sync_cs (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (cs),
    .q       (cs_sync)
  );

  logic                  sclk_prev_q, sclk_prev_d;
  logic                  cs_prev_q, cs_prev_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [CW-1:0]         bit_count_q, bit_count_d;
  logic                  load_pending_q, load_pending_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  underrun_q, underrun_d;

  logic sclk_rise, sclk_fall;
  logic lead_edge, trail_edge;
  logic sample_edge, shift_edge;
  logic cs_fall, cs_rise, selected;
  logic do_load;

  always_comb begin
    sclk_rise   = sclk_sync & ~sclk_prev_q;
    sclk_fall   = ~sclk_sync & sclk_prev_q;
    lead_edge   = CPOL ? sclk_fall : sclk_rise;
    trail_edge  = CPOL ? sclk_rise : sclk_fall;
    sample_edge = CPHA ? trail_edge : lead_edge;
    shift_edge  = CPHA ? lead_edge : trail_edge;
    cs_fall     = ~cs_sync & cs_prev_q;
    cs_rise     = cs_sync & ~cs_prev_q;
    selected    = ~cs_sync;
  end

  always_comb begin
    sclk_prev_d    = sclk_sync;
    cs_prev_d      = cs_sync;
    tx_shift_d     = tx_shift_q;
    rx_shift_d     = rx_shift_q;
    bit_count_d    = bit_count_q;
    load_pending_d = load_pending_q;
    hold_d         = hold_q;
    hold_valid_d   = hold_valid_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    underrun_d     = 1'b0;
    do_load        = 1'b0;

    if (cs_fall) begin
      bit_count_d = '0;
      if (CPHA) load_pending_d = 1'b1;
      else      do_load        = 1'b1;
    end else if (cs_rise) begin
      // Partial word is dropped; next frame restarts at bit 0.
      bit_count_d    = '0;
      load_pending_d = 1'b0;
    end else if (selected) begin
      if (sample_edge) begin
        rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync};
        if (bit_count_q == CW'(DATA_WIDTH - 1)) begin
          rx_data_d      = rx_shift_d;
          rx_valid_d     = 1'b1;
          bit_count_d    = '0;
          load_pending_d = 1'b1;
        end else begin
          bit_count_d = bit_count_q + CW'(1);
        end
      end
      if (shift_edge) begin
        if (load_pending_q) begin
          do_load        = 1'b1;
          load_pending_d = 1'b0;
        end else begin
          tx_shift_d = tx_shift_q << 1;
        end
      end
    end

    if (do_load) begin
      if (hold_valid_q) begin
        tx_shift_d   = hold_q;
        hold_valid_d = 1'b0;
      end else begin
        tx_shift_d = IDLE_WORD;
        underrun_d = 1'b1;
      end
    end

    // Write only when empty, so it never races a load of valid data.
    if (tx_valid && !hold_valid_q) begin
      hold_d       = tx_data;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_prev_q    <= CPOL;
      cs_prev_q      <= 1'b1;
      tx_shift_q     <= '0;
      rx_shift_q     <= '0;
      bit_count_q    <= '0;
      load_pending_q <= 1'b0;
      hold_q         <= '0;
      hold_valid_q   <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      sclk_prev_q    <= sclk_prev_d;
      cs_prev_q      <= cs_prev_d;
      tx_shift_q     <= tx_shift_d;
      rx_shift_q     <= rx_shift_d;
      bit_count_q    <= bit_count_d;
      load_pending_q <= load_pending_d;
      hold_q         <= hold_d;
      hold_valid_q   <= hold_valid_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      underrun_q     <= underrun_d;
    end
  end

  assign miso               = tx_shift_q[DATA_WIDTH-1];
  assign miso_output_enable = selected;
  assign tx_ready           = ~hold_valid_q;
  assign rx_data            = rx_data_q;
  assign rx_valid           = rx_valid_q;
  assign tx_underrun        = underrun_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: one instance per SPI mode (index = {CPOL,CPHA}).
// Each test task drives a controller model and checks against fixed vectors.
module tb_spi_target;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] sclk_v = 4'b1100;
  logic [3:0] cs_v = 4'hF;
  logic [3:0] mosi_v = 4'h0;
  logic [3:0] tx_valid_v = 4'h0;
  logic [7:0] tx_data_a [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [3:0] miso_v, oe_v, tx_ready_v, rx_valid_v, und_v;
  logic [7:0] rx_data_a [4];

  int n_cmp = 0;
  int n_fail = 0;
  int rxv_cnt [4] = '{0, 0, 0, 0};
  int und_cnt [4] = '{0, 0, 0, 0};
  logic [15:0] rx_hist [4] = '{16'h0, 16'h0, 16'h0, 16'h0};

  always #5 clock = ~clock;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_target #(
      .CPOL       (bit'((g >> 1) & 1)),
      .CPHA       (bit'(g & 1)),
      .DATA_WIDTH (8)
    ) u_dut (
      .clock              (clock),
      .reset_n            (reset_n),
      .sclk               (sclk_v[g]),
      .mosi               (mosi_v[g]),
      .cs                 (cs_v[g]),
      .miso               (miso_v[g]),
      .miso_output_enable (oe_v[g]),
      .tx_data            (tx_data_a[g]),
      .tx_valid           (tx_valid_v[g]),
      .tx_ready           (tx_ready_v[g]),
      .rx_data            (rx_data_a[g]),
      .rx_valid           (rx_valid_v[g]),
      .tx_underrun        (und_v[g])
    );
  end

  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_valid_v[i]) begin
        rxv_cnt[i] <= rxv_cnt[i] + 1;
        rx_hist[i] <= {rx_hist[i][7:0], rx_data_a[i]};
      end
      if (und_v[i]) und_cnt[i] <= und_cnt[i] + 1;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic write_tx(input int m, input logic [7:0] d);
    int t;
    t = 0;
    while (!tx_ready_v[m] && t < 300) begin
      wait_clk(1);
      t++;
    end
    n_cmp++;
    if (t >= 300) begin
      n_fail++;
      $display("FAIL write_tx_timeout m%0d: tx_ready=%b required 1", m, tx_ready_v[m]);
    end else begin
      tx_data_a[m] = d;
      tx_valid_v[m] = 1'b1;
      wait_clk(1);
      tx_valid_v[m] = 1'b0;
    end
  endtask

  // Controller model, sclk half period = 4 system clocks.
  task automatic frame(input int m, input int nbits, input logic [15:0] mo,
                       output logic [15:0] mi);
    logic cpol, cpha;
    logic [15:0] acc;
    cpol = m[1];
    cpha = m[0];
    acc = '0;
    cs_v[m] = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) mosi_v[m] = mo[15-i];
      wait_clk(4);
      sclk_v[m] = ~cpol;
      if (cpha) mosi_v[m] = mo[15-i];
      else acc = {acc[14:0], miso_v[m]};
      wait_clk(4);
      sclk_v[m] = cpol;
      if (cpha) acc = {acc[14:0], miso_v[m]};
    end
    wait_clk(4);
    cs_v[m] = 1'b1;
    wait_clk(6);
    mi = acc;
  endtask

  task automatic test_reset;
    wait_clk(3);
    n_cmp++; if (miso_v !== 4'h0) begin n_fail++; $display("FAIL rst_miso: %b required 0000", miso_v); end
    n_cmp++; if (oe_v !== 4'h0) begin n_fail++; $display("FAIL rst_oe: %b required 0000", oe_v); end
    n_cmp++; if (tx_ready_v !== 4'hF) begin n_fail++; $display("FAIL rst_tx_ready: %b required 1111", tx_ready_v); end
    n_cmp++; if (rx_valid_v !== 4'h0) begin n_fail++; $display("FAIL rst_rx_valid: %b required 0000", rx_valid_v); end
    n_cmp++; if (und_v !== 4'h0) begin n_fail++; $display("FAIL rst_underrun: %b required 0000", und_v); end
    n_cmp++; if (rx_data_a[0] !== 8'h00) begin n_fail++; $display("FAIL rst_rx_data: %h required 00", rx_data_a[0]); end
    reset_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_mode0;
    logic [15:0] mi;
    int c0;
    write_tx(0, 8'hA5);
    wait_clk(1);
    n_cmp++; if (tx_ready_v[0] !== 1'b0) begin n_fail++; $display("FAIL m0_ready_low: %b required 0", tx_ready_v[0]); end
    c0 = rxv_cnt[0];
    frame(0, 8, 16'h3C00, mi);
    n_cmp++; if (mi[7:0] !== 8'hA5) begin n_fail++; $display("FAIL m0_miso: %h required a5", mi[7:0]); end
    n_cmp++; if (rx_data_a[0] !== 8'h3C) begin n_fail++; $display("FAIL m0_rx: %h required 3c", rx_data_a[0]); end
    n_cmp++; if (rxv_cnt[0] - c0 !== 1) begin n_fail++; $display("FAIL m0_rxv: %0d required 1", rxv_cnt[0] - c0); end
    n_cmp++; if (tx_ready_v[0] !== 1'b1) begin n_fail++; $display("FAIL m0_ready_high: %b required 1", tx_ready_v[0]); end
  endtask

  task automatic test_mode_sweep;
    logic [15:0] mi;
    int c0;
    for (int m = 1; m < 4; m++) begin
      write_tx(m, 8'h5A);
      c0 = rxv_cnt[m];
      frame(m, 8, 16'hC300, mi);
      n_cmp++; if (mi[7:0] !== 8'h5A) begin n_fail++; $display("FAIL sweep_miso m%0d: %h required 5a", m, mi[7:0]); end
      n_cmp++; if (rx_data_a[m] !== 8'hC3) begin n_fail++; $display("FAIL sweep_rx m%0d: %h required c3", m, rx_data_a[m]); end
      n_cmp++; if (rxv_cnt[m] - c0 !== 1) begin n_fail++; $display("FAIL sweep_rxv m%0d: %0d required 1", m, rxv_cnt[m] - c0); end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] mi;
    int c0, u0;
    write_tx(3, 8'h11);
    c0 = rxv_cnt[3];
    u0 = und_cnt[3];
    fork
      frame(3, 16, 16'hA55A, mi);
      write_tx(3, 8'h22);
    join
    n_cmp++; if (mi !== 16'h1122) begin n_fail++; $display("FAIL b2b_miso: %h required 1122", mi); end
    n_cmp++; if (rx_hist[3] !== 16'hA55A) begin n_fail++; $display("FAIL b2b_rx: %h required a55a", rx_hist[3]); end
    n_cmp++; if (rxv_cnt[3] - c0 !== 2) begin n_fail++; $display("FAIL b2b_rxv: %0d required 2", rxv_cnt[3] - c0); end
    n_cmp++; if (und_cnt[3] - u0 !== 0) begin n_fail++; $display("FAIL b2b_underrun: %0d required 0", und_cnt[3] - u0); end
  endtask

  task automatic test_underrun;
    logic [15:0] mi;
    int u0;
    u0 = und_cnt[1];
    frame(1, 8, 16'h2400, mi);
    n_cmp++; if (mi[7:0] !== 8'hFF) begin n_fail++; $display("FAIL und_miso: %h required ff", mi[7:0]); end
    n_cmp++; if (und_cnt[1] - u0 !== 1) begin n_fail++; $display("FAIL und_count: %0d required 1", und_cnt[1] - u0); end
    n_cmp++; if (rx_data_a[1] !== 8'h24) begin n_fail++; $display("FAIL und_rx: %h required 24", rx_data_a[1]); end
  endtask

  task automatic test_cs_abort;
    logic [15:0] mi;
    int c0;
    c0 = rxv_cnt[0];
    frame(0, 5, 16'hF800, mi);
    n_cmp++; if (rxv_cnt[0] - c0 !== 0) begin n_fail++; $display("FAIL abort_rxv: %0d required 0", rxv_cnt[0] - c0); end
    n_cmp++; if (oe_v[0] !== 1'b0) begin n_fail++; $display("FAIL abort_oe: %b required 0", oe_v[0]); end
    n_cmp++; if (rx_data_a[0] !== 8'h3C) begin n_fail++; $display("FAIL abort_rx_hold: %h required 3c", rx_data_a[0]); end
    c0 = rxv_cnt[0];
    frame(0, 8, 16'hE700, mi);
    n_cmp++; if (rx_data_a[0] !== 8'hE7) begin n_fail++; $display("FAIL abort_next_rx: %h required e7", rx_data_a[0]); end
    n_cmp++; if (rxv_cnt[0] - c0 !== 1) begin n_fail++; $display("FAIL abort_next_rxv: %0d required 1", rxv_cnt[0] - c0); end
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] mi;
    write_tx(0, 8'h69);
    cs_v[0] = 1'b0;
    mosi_v[0] = 1'b1;
    wait_clk(10);
    sclk_v[0] = 1'b1;
    wait_clk(4);
    sclk_v[0] = 1'b0;
    wait_clk(4);
    n_cmp++; if (oe_v[0] !== 1'b1) begin n_fail++; $display("FAIL mid_oe_sel: %b required 1", oe_v[0]); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (oe_v !== 4'h0) begin n_fail++; $display("FAIL mid_rst_oe: %b required 0000", oe_v); end
    n_cmp++; if (miso_v !== 4'h0) begin n_fail++; $display("FAIL mid_rst_miso: %b required 0000", miso_v); end
    n_cmp++; if (tx_ready_v !== 4'hF) begin n_fail++; $display("FAIL mid_rst_ready: %b required 1111", tx_ready_v); end
    n_cmp++; if (rx_data_a[0] !== 8'h00) begin n_fail++; $display("FAIL mid_rst_rx: %h required 00", rx_data_a[0]); end
    n_cmp++; if (rx_valid_v !== 4'h0 || und_v !== 4'h0) begin n_fail++; $display("FAIL mid_rst_pulses: rxv=%b und=%b required 0", rx_valid_v, und_v); end
    cs_v[0] = 1'b1;
    mosi_v[0] = 1'b0;
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(4);
    write_tx(0, 8'h81);
    frame(0, 8, 16'h4200, mi);
    n_cmp++; if (mi[7:0] !== 8'h81) begin n_fail++; $display("FAIL post_rst_miso: %h required 81", mi[7:0]); end
    n_cmp++; if (rx_data_a[0] !== 8'h42) begin n_fail++; $display("FAIL post_rst_rx: %h required 42", rx_data_a[0]); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode_sweep();
    test_back_to_back();
    test_underrun();
    test_cs_abort();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
